page_buf_arbiter: RTL and testbench

- Arbitrates and sequences one single-port page buffer (PageWords x DataWidth) between the host side and the NAND controller side.
- Grants exclusive ownership to one side per page transfer and generates the buffer select, read-enable, write-enable and address.
- Tracks page-valid status for each direction and drives buf_cntrl_status and host_buf_status.
- Sits between the host interface and the buffer RAM. The RAM is external, single-port, with 1-cycle read latency.

---
 rtl/page_buf_pkg.sv | 33 +++
 rtl/page_buf_arbiter_counter.sv | 32 +++
 rtl/page_buf_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_page_buf_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_buf_pkg.sv
// Shared constants, state encoding and helpers for the page buffer arbiter.
// The optional idle-strobe timeout is enabled by defining PAGE_BUF_ARB_TIMEOUT_EN.
package page_buf_pkg;

   localparam int DataWidth     = 16;
   localparam int PageWords     = 2048;
   localparam int AddrWidth     = 11;
   localparam int TimeoutCycles = 1024;

   localparam logic DIR_WR = 1'b1;
   localparam logic DIR_RD = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOST_WR = 3'd1,
      ST_HOST_RD = 3'd2,
      ST_CTRL_WR = 3'd3,
      ST_CTRL_RD = 3'd4
   } arb_state_t;

   function automatic logic st_is_wr(input arb_state_t s);
      return (s == ST_HOST_WR) || (s == ST_CTRL_WR);
   endfunction

   function automatic logic st_is_host(input arb_state_t s);
      return (s == ST_HOST_WR) || (s == ST_HOST_RD);
   endfunction

   function automatic logic st_is_ctrl(input arb_state_t s);
      return (s == ST_CTRL_WR) || (s == ST_CTRL_RD);
   endfunction

endpackage

// File: rtl/page_buf_arbiter_counter.sv
// Page word counter: synchronous clear, increment, and terminal-count flag.
// Saturates at the last word so a page can never wrap onto address 0.
module page_word_counter #(
   parameter int AddrWidth = 11,
   parameter int PageWords = 2048
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_inc,
   output logic [AddrWidth-1:0] o_count,
   output logic                 o_tc
);

   localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(PageWords - 1);

   logic [AddrWidth-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != LastIdx)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == LastIdx);

endmodule

// File: rtl/page_buf_arbiter.sv
// Single-port page buffer arbiter between host and NAND controller sides.
// Define PAGE_BUF_ARB_TIMEOUT_EN to abort transfers whose owner stops strobing.
module page_buf_arbiter #(
   parameter int DataWidth = page_buf_pkg::DataWidth,
   parameter int PageWords = page_buf_pkg::PageWords,
   parameter int AddrWidth = page_buf_pkg::AddrWidth
`ifdef PAGE_BUF_ARB_TIMEOUT_EN
   ,parameter int TimeoutCycles = page_buf_pkg::TimeoutCycles
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 host_req,
   input  logic                 host_dir,
   output logic                 host_gnt,
   input  logic                 host_stb,
   input  logic [DataWidth-1:0] host_wdata,
   output logic [DataWidth-1:0] host_rdata,
   output logic                 host_rvalid,
   output logic                 host_done,
   input  logic                 ctrl_req,
   input  logic                 ctrl_dir,
   output logic                 ctrl_gnt,
   input  logic                 ctrl_stb,
   input  logic [DataWidth-1:0] ctrl_wdata,
   output logic [DataWidth-1:0] ctrl_rdata,
   output logic                 ctrl_rvalid,
   output logic                 ctrl_done,
   output logic                 mem_sel,
   output logic                 mem_we,
   output logic                 mem_re,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata,
   output logic                 buf_cntrl_status,
   output logic                 host_buf_status,
   output logic                 arb_err
);

   import page_buf_pkg::*;

   arb_state_t           r_state;
   logic                 r_last_ctrl;
   logic                 r_bc;
   logic                 r_hb;
   logic                 r_host_done;
   logic                 r_ctrl_done;
   logic                 r_err;
   logic                 r_host_rvalid;
   logic                 r_ctrl_rvalid;
   logic [DataWidth-1:0] r_host_rhold;
   logic [DataWidth-1:0] r_ctrl_rhold;

   logic [AddrWidth-1:0] w_count;
   logic                 w_tc;
   logic                 w_host_own;
   logic                 w_ctrl_own;
   logic                 w_granted;
   logic                 w_own_wr;
   logic                 w_own_req;
   logic                 w_sel;
   logic                 w_last;
   logic                 w_timeout;
   logic                 w_abort;
   logic                 w_flags_clr;
   logic                 w_arb_ok;
   logic                 w_host_elig;
   logic                 w_ctrl_elig;
   logic                 w_host_win;
   logic                 w_ctrl_win;
   logic                 w_grant;

   assign w_host_own = st_is_host(r_state);
   assign w_ctrl_own = st_is_ctrl(r_state);
   assign w_granted  = w_host_own | w_ctrl_own;
   assign w_own_wr   = st_is_wr(r_state);
   assign w_own_req  = (w_host_own & host_req) | (w_ctrl_own & ctrl_req);
   assign w_sel      = (w_host_own & host_stb) | (w_ctrl_own & ctrl_stb);
   assign w_last     = w_sel & w_tc;
   assign w_abort    = w_granted & ~w_last & (~w_own_req | w_timeout);

   // The cycle after done/abort is kept out of arbitration: the finishing
   // side still holds its request while it observes done.
   assign w_flags_clr = ~r_bc & ~r_hb;
   assign w_arb_ok    = (r_state == ST_IDLE) & ~r_host_done & ~r_ctrl_done & ~r_err;
   assign w_host_elig = host_req & ((host_dir == DIR_WR) ? w_flags_clr : r_hb);
   assign w_ctrl_elig = ctrl_req & ((ctrl_dir == DIR_WR) ? w_flags_clr : r_bc);
   assign w_host_win  = w_arb_ok & w_host_elig & (~w_ctrl_elig | r_last_ctrl);
   assign w_ctrl_win  = w_arb_ok & w_ctrl_elig & ~w_host_win;
   assign w_grant     = w_host_win | w_ctrl_win;

   page_word_counter #(
      .AddrWidth (AddrWidth),
      .PageWords (PageWords)
   ) u_word_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_grant | w_last | w_abort),
      .i_inc   (w_sel),
      .o_count (w_count),
      .o_tc    (w_tc)
   );

`ifdef PAGE_BUF_ARB_TIMEOUT_EN
   localparam int ToWidth = $clog2(TimeoutCycles + 1);

   logic [ToWidth-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (w_grant || w_sel || !w_granted) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = w_granted & (r_to_cnt == ToWidth'(TimeoutCycles));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_last_ctrl <= 1'b1;
         r_bc        <= 1'b0;
         r_hb        <= 1'b0;
         r_host_done <= 1'b0;
         r_ctrl_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_host_done <= 1'b0;
         r_ctrl_done <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_host_win) begin
                  r_state     <= (host_dir == DIR_WR) ? ST_HOST_WR : ST_HOST_RD;
                  r_last_ctrl <= 1'b0;
               end else if (w_ctrl_win) begin
                  r_state     <= (ctrl_dir == DIR_WR) ? ST_CTRL_WR : ST_CTRL_RD;
                  r_last_ctrl <= 1'b1;
               end
            end
            default: begin
               if (w_last) begin
                  r_state     <= ST_IDLE;
                  r_host_done <= w_host_own;
                  r_ctrl_done <= w_ctrl_own;
                  case (r_state)
                     ST_HOST_WR: r_bc <= 1'b1;
                     ST_CTRL_RD: r_bc <= 1'b0;
                     ST_CTRL_WR: r_hb <= 1'b1;
                     ST_HOST_RD: r_hb <= 1'b0;
                     default:    ;
                  endcase
               end else if (w_abort) begin
                  r_state <= ST_IDLE;
                  r_err   <= 1'b1;
               end
            end
         endcase
      end
   end

   // Read data is forwarded from the RAM in the rvalid cycle and held after;
   // any new grant clears both holds so a non-owner never shows stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_host_rvalid <= 1'b0;
         r_ctrl_rvalid <= 1'b0;
         r_host_rhold  <= '0;
         r_ctrl_rhold  <= '0;
      end else begin
         r_host_rvalid <= w_sel & (r_state == ST_HOST_RD);
         r_ctrl_rvalid <= w_sel & (r_state == ST_CTRL_RD);
         if (w_grant) begin
            r_host_rhold <= '0;
            r_ctrl_rhold <= '0;
         end else begin
            if (r_host_rvalid) r_host_rhold <= mem_rdata;
            if (r_ctrl_rvalid) r_ctrl_rhold <= mem_rdata;
         end
      end
   end

   assign host_gnt         = w_host_own;
   assign ctrl_gnt         = w_ctrl_own;
   assign host_done        = r_host_done;
   assign ctrl_done        = r_ctrl_done;
   assign arb_err          = r_err;
   assign buf_cntrl_status = r_bc;
   assign host_buf_status  = r_hb;

   assign host_rvalid = r_host_rvalid;
   assign ctrl_rvalid = r_ctrl_rvalid;
   assign host_rdata  = r_host_rvalid ? mem_rdata : r_host_rhold;
   assign ctrl_rdata  = r_ctrl_rvalid ? mem_rdata : r_ctrl_rhold;

   assign mem_sel   = w_sel;
   assign mem_we    = w_sel & w_own_wr;
   assign mem_re    = w_sel & ~w_own_wr;
   assign mem_addr  = w_sel ? w_count : '0;
   assign mem_wdata = (w_sel & w_own_wr) ? (w_host_own ? host_wdata : ctrl_wdata) : '0;

endmodule

// File: tb/tb_page_buf_arbiter.sv
// Randomized bench for page_buf_arbiter with a page-level reference model,
// a simple 1-cycle-latency RAM, and a per-cycle output comparison.
module tb_page_buf_arbiter;
   import page_buf_pkg::*;

   localparam int DW = DataWidth;
   localparam int PW = PageWords;
   localparam int AW = AddrWidth;
`ifdef PAGE_BUF_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          host_req = 1'b0, host_dir = 1'b0, host_stb = 1'b0;
   logic [DW-1:0] host_wdata = '0;
   logic          ctrl_req = 1'b0, ctrl_dir = 1'b0, ctrl_stb = 1'b0;
   logic [DW-1:0] ctrl_wdata = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic          host_gnt, host_rvalid, host_done, ctrl_gnt, ctrl_rvalid, ctrl_done;
   logic [DW-1:0] host_rdata, ctrl_rdata, mem_wdata;
   logic          mem_sel, mem_we, mem_re, buf_cntrl_status, host_buf_status, arb_err;
   logic [AW-1:0] mem_addr;

   int n_cmp = 0;
   int n_err = 0;

   page_buf_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_dir(host_dir), .host_gnt(host_gnt), .host_stb(host_stb),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .host_done(host_done),
      .ctrl_req(ctrl_req), .ctrl_dir(ctrl_dir), .ctrl_gnt(ctrl_gnt), .ctrl_stb(ctrl_stb),
      .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata), .ctrl_rvalid(ctrl_rvalid),
      .ctrl_done(ctrl_done),
      .mem_sel(mem_sel), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .buf_cntrl_status(buf_cntrl_status), .host_buf_status(host_buf_status),
      .arb_err(arb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // External RAM
   logic [DW-1:0] ram [PW] = '{default: '0};
   always @(posedge clk) begin
      if (mem_sel && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_sel && mem_re) mem_rdata <= ram[mem_addr];
   end

   // Reference model: owner (0 none, 1 host, 2 ctrl), word index, status flags
   int            m_own = 0;
   bit            m_wr = 0;
   int            m_cnt = 0;
   int            m_tc = 0;
   bit            m_bc = 0, m_hb = 0, m_last_ctrl = 1;
   bit            m_hdone = 0, m_cdone = 0, m_err = 0;
   bit            m_hrv = 0, m_crv = 0;
   logic [DW-1:0] m_hrd = '0, m_crd = '0, m_hhold = '0, m_chold = '0;
   logic [DW-1:0] m_page [PW] = '{default: '0};

   always @(posedge clk or negedge rst_n) begin
      bit blk, he, ce, stb, req, hrv_n, crv_n, flags_clr;
      logic [DW-1:0] wd;
      if (!rst_n) begin
         m_own = 0; m_cnt = 0; m_tc = 0; m_bc = 0; m_hb = 0; m_last_ctrl = 1;
         m_hdone = 0; m_cdone = 0; m_err = 0; m_hrv = 0; m_crv = 0;
         m_hrd = '0; m_crd = '0; m_hhold = '0; m_chold = '0;
      end else begin
         if (m_hrv) m_hhold = m_hrd;
         if (m_crv) m_chold = m_crd;
         hrv_n = 0; crv_n = 0;
         blk = m_hdone | m_cdone | m_err;
         m_hdone = 0; m_cdone = 0; m_err = 0;
         if (m_own == 0) begin
            flags_clr = !m_bc && !m_hb;
            he = host_req && (host_dir ? flags_clr : m_hb);
            ce = ctrl_req && (ctrl_dir ? flags_clr : m_bc);
            if (!blk && he && (!ce || m_last_ctrl)) begin
               m_own = 1; m_wr = host_dir; m_last_ctrl = 0;
            end else if (!blk && ce) begin
               m_own = 2; m_wr = ctrl_dir; m_last_ctrl = 1;
            end
            if (m_own != 0) begin
               m_cnt = 0; m_tc = 0; m_hhold = '0; m_chold = '0;
            end
         end else begin
            stb = (m_own == 1) ? host_stb : ctrl_stb;
            req = (m_own == 1) ? host_req : ctrl_req;
            wd  = (m_own == 1) ? host_wdata : ctrl_wdata;
            if (stb) begin
               if (m_wr) m_page[m_cnt] = wd;
               else if (m_own == 1) begin hrv_n = 1; m_hrd = m_page[m_cnt]; end
               else begin crv_n = 1; m_crd = m_page[m_cnt]; end
            end
            if (stb && m_cnt == PW - 1) begin
               if (m_own == 1 && m_wr)  m_bc = 1;
               if (m_own == 2 && !m_wr) m_bc = 0;
               if (m_own == 2 && m_wr)  m_hb = 1;
               if (m_own == 1 && !m_wr) m_hb = 0;
               if (m_own == 1) m_hdone = 1; else m_cdone = 1;
               m_own = 0;
            end else if (!req || (TO_EN && m_tc == TimeoutCycles)) begin
               m_err = 1; m_own = 0;
            end else if (stb) begin
               m_cnt++;
            end
            if (stb) m_tc = 0; else m_tc++;
         end
         m_hrv = hrv_n; m_crv = crv_n;
      end
   end

   // Per-cycle comparison, mid-cycle
   always @(negedge clk) begin
      logic          ostb;
      logic [DW-1:0] ewd;
      ostb = (m_own == 1) ? host_stb : (m_own == 2) ? ctrl_stb : 1'b0;
      ewd  = (ostb && m_wr) ? ((m_own == 1) ? host_wdata : ctrl_wdata) : '0;
      chk("host_gnt", 32'(host_gnt), 32'(m_own == 1));
      chk("ctrl_gnt", 32'(ctrl_gnt), 32'(m_own == 2));
      chk("host_done", 32'(host_done), 32'(m_hdone));
      chk("ctrl_done", 32'(ctrl_done), 32'(m_cdone));
      chk("arb_err", 32'(arb_err), 32'(m_err));
      chk("buf_cntrl_status", 32'(buf_cntrl_status), 32'(m_bc));
      chk("host_buf_status", 32'(host_buf_status), 32'(m_hb));
      chk("mem_sel", 32'(mem_sel), 32'(ostb));
      chk("mem_we", 32'(mem_we), 32'(ostb && m_wr));
      chk("mem_re", 32'(mem_re), 32'(ostb && !m_wr));
      chk("mem_addr", 32'(mem_addr), ostb ? 32'(m_cnt) : 32'd0);
      chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_hrv));
      chk("ctrl_rvalid", 32'(ctrl_rvalid), 32'(m_crv));
      chk("host_rdata", 32'(host_rdata), 32'(m_hrv ? m_hrd : m_hhold));
      chk("ctrl_rdata", 32'(ctrl_rdata), 32'(m_crv ? m_crd : m_chold));
   end

   // Controller read-data capture for the sequential-pattern check
   bit            collect = 0;
   logic [DW-1:0] rq [$];
   always @(negedge clk) if (collect && ctrl_rvalid) rq.push_back(ctrl_rdata);

   task automatic set_side(input int side, input logic req, input logic stb, input logic [DW-1:0] wd);
      if (side == 0) begin host_req = req; host_stb = stb; host_wdata = wd; end
      else begin ctrl_req = req; ctrl_stb = stb; ctrl_wdata = wd; end
   endtask

   // One page transfer for one side; tasks run aligned to posedge+1
   task automatic xfer(input int side, input logic dir, input int drop_at, input int rst_at,
                       input bit seq, input bit chk_first);
      int n, w;
      bit g, s, first;
      logic [DW-1:0] wd;
      if (side == 0) host_dir = dir; else ctrl_dir = dir;
      set_side(side, 1'b1, 1'b0, '0);
      g = 0; w = 0;
      while (!g && w < 400) begin
         @(posedge clk); #1;
         g = (side == 0) ? host_gnt : ctrl_gnt;
         w++;
      end
      chk("grant_wait", 32'(g), 32'd1);
      if (!g) begin set_side(side, 1'b0, 1'b0, '0); return; end
      n = 0; first = 1;
      while (n < PW) begin
         if (n == drop_at) begin
            set_side(side, 1'b0, 1'b0, '0);
            @(posedge clk); #1;
            chk("abort_err", 32'(arb_err), 32'd1);
            chk("abort_gnt", 32'(side == 0 ? host_gnt : ctrl_gnt), 32'd0);
            chk("abort_bc", 32'(buf_cntrl_status), 32'd0);
            chk("abort_hb", 32'(host_buf_status), 32'd0);
            return;
         end
         s  = ($urandom_range(3) != 0) || (n == rst_at);
         wd = seq ? DW'(n) : DW'($urandom);
         set_side(side, 1'b1, s, wd);
         if (n == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_gnt", 32'({host_gnt, ctrl_gnt}), 32'd0);
            chk("rst_mem", 32'({mem_sel, mem_we, mem_re}), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_flags", 32'({buf_cntrl_status, host_buf_status}), 32'd0);
            chk("rst_pulses", 32'({host_done, ctrl_done, arb_err}), 32'd0);
            @(posedge clk); #1;
            set_side(side, 1'b0, 1'b0, '0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         if (s && first && chk_first) begin
            #1 chk("first_addr", 32'(mem_addr), 32'd0);
         end
         if (s) first = 0;
         @(posedge clk); #1;
         if (s) n++;
      end
      set_side(side, 1'b1, 1'b0, '0);
      chk("done_pulse", 32'(side == 0 ? host_done : ctrl_done), 32'd1);
      @(posedge clk); #1;
      set_side(side, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int nbad, hw, cw;
      bit g, e;
      repeat (3) @(posedge clk); #1;
      chk("reset_gnt", 32'({host_gnt, ctrl_gnt}), 32'd0);
      chk("reset_mem", 32'({mem_sel, mem_we, mem_re}), 32'd0);
      chk("reset_status", 32'({buf_cntrl_status, host_buf_status, arb_err}), 32'd0);
      rst_n = 1'b1;

      // Simultaneous writes from reset: host wins, data = word index
      ctrl_dir = 1'b1; ctrl_req = 1'b1;
      xfer(0, DIR_WR, -1, -1, 1'b1, 1'b1);
      chk("bc_after_host_wr", 32'(buf_cntrl_status), 32'd1);
      chk("hb_after_host_wr", 32'(host_buf_status), 32'd0);
      repeat (50) @(posedge clk); #1;
      chk("ctrl_wr_blocked", 32'(ctrl_gnt), 32'd0);
      ctrl_req = 1'b0; ctrl_dir = 1'b0;
      @(posedge clk); #1;

      // Controller reads the page back in order
      rq.delete(); collect = 1;
      xfer(1, DIR_RD, -1, -1, 1'b0, 1'b1);
      collect = 0;
      chk("ctrl_rd_count", 32'(rq.size()), 32'(PW));
      nbad = 0;
      foreach (rq[i]) if (rq[i] !== DW'(i)) nbad++;
      chk("ctrl_rd_seq", 32'(nbad), 32'd0);
      chk("bc_after_ctrl_rd", 32'(buf_cntrl_status), 32'd0);

      // Host read with nothing pending stays ungranted without error
      host_dir = DIR_RD; host_req = 1'b1; g = 0; e = 0;
      repeat (100) begin
         @(posedge clk); #1;
         g |= host_gnt; e |= arb_err;
      end
      chk("ineligible_gnt", 32'(g), 32'd0);
      chk("ineligible_err", 32'(e), 32'd0);
      host_req = 1'b0;
      @(posedge clk); #1;

      // Controller write, host read
      xfer(1, DIR_WR, -1, -1, 1'b0, 1'b0);
      chk("hb_after_ctrl_wr", 32'(host_buf_status), 32'd1);
      xfer(0, DIR_RD, -1, -1, 1'b0, 1'b0);
      chk("hb_after_host_rd", 32'(host_buf_status), 32'd0);

      // Host abort at word 500, then a full page restarting at address 0
      xfer(0, DIR_WR, 500, -1, 1'b0, 1'b0);
      xfer(0, DIR_WR, -1, -1, 1'b0, 1'b1);
      xfer(1, DIR_RD, -1, -1, 1'b0, 1'b0);

      // Reset in the middle of a controller write
      xfer(1, DIR_WR, -1, 1000, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Random contention on both sides
      hw = 0; cw = 0;
      for (int c = 0; c < 12000; c++) begin
         if (!host_req) begin
            if ($urandom_range(7) == 0) begin host_req = 1'b1; host_dir = 1'($urandom_range(1)); hw = 0; end
         end else begin
            if (!host_gnt) hw++;
            if (host_done || hw > 80 || (host_gnt && $urandom_range(3999) == 0)) host_req = 1'b0;
         end
         if (!ctrl_req) begin
            if ($urandom_range(7) == 0) begin ctrl_req = 1'b1; ctrl_dir = 1'($urandom_range(1)); cw = 0; end
         end else begin
            if (!ctrl_gnt) cw++;
            if (ctrl_done || cw > 80 || (ctrl_gnt && $urandom_range(3999) == 0)) ctrl_req = 1'b0;
         end
         host_stb = ($urandom_range(3) != 0); host_wdata = DW'($urandom);
         ctrl_stb = ($urandom_range(3) != 0); ctrl_wdata = DW'($urandom);
         @(posedge clk); #1;
      end
      set_side(0, 1'b0, 1'b0, '0);
      set_side(1, 1'b0, 1'b0, '0);
      repeat (4) @(posedge clk); #1;

`ifdef PAGE_BUF_ARB_TIMEOUT_EN
      begin
         int k, kerr;
         rst_n = 1'b0; #2; rst_n = 1'b1;
         @(posedge clk); #1;
         host_dir = DIR_WR; host_req = 1'b1;
         @(posedge clk); #1;
         chk("tmo_grant", 32'(host_gnt), 32'd1);
         kerr = -1;
         for (k = 1; k <= TimeoutCycles + 20; k++) begin
            @(posedge clk); #1;
            if (arb_err && kerr < 0) kerr = k;
         end
         chk("tmo_err_cycle", 32'(kerr), 32'(TimeoutCycles + 1));
         host_req = 1'b0;
         repeat (2) @(posedge clk); #1;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
